// File: rtl/mac_serial_accumulator.sv
// mac_serial_accumulator
//   Unsigned multiply-accumulate stage. One a/b operand pair is accepted per
//   valid/ready handshake. The product is built bit-serially (one shift-add
//   pass per cycle through a ripple full-adder chain) and then added into a
//   running accumulator. A one-cycle out_valid strobe marks each update.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous, active-high reset
//     in_valid   operand pair present on a/b
//     in_ready   block idle and able to accept operands
//     a, b       WIDTH-bit unsigned multiplicand / multiplier
//     clear      zero accumulator and overflow (honoured only while idle)
//     acc_out    accumulator register
//     out_valid  one-cycle pulse: acc_out has just been updated
//     overflow   sticky flag, set when an accumulate carries out of ACC_WIDTH
//
//   Build option: define MAC_SATURATE_EN to saturate acc_out to all ones on
//   carry-out; otherwise the accumulator wraps modulo 2^ACC_WIDTH.
//
//   state | meaning
//   IDLE  | waiting for a handshake; clear honoured here
//   MUL   | WIDTH shift-add passes forming the product
//   ACC   | single edge adding the product into the accumulator
module mac_serial_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  output logic                 overflow
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   a_shift;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]   partial;
  logic [CW-1:0]   count;

  logic            fire;
  logic            mul_last;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   psum;
  logic [PW-1:0]   carry;
  logic [ACC_WIDTH:0] acc_sum;

  assign in_ready = (state == IDLE);
  assign fire     = in_valid && in_ready;
  assign mul_last = (count == CW'(WIDTH - 1));

  // Ripple chain of 1-bit full adders: partial + (b_reg[0] ? a_shift : 0).
  // The product fits in PW bits, so the final carry is never needed.
  assign addend   = b_reg[0] ? a_shift : '0;
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < PW; i++) begin : g_fa
    assign psum[i] = partial[i] ^ addend[i] ^ carry[i];
    if (i < PW - 1) begin : g_carry
      assign carry[i+1] = (partial[i] & addend[i]) |
                          (carry[i] & (partial[i] ^ addend[i]));
    end
  end

  assign acc_sum = {1'b0, acc_out} + (ACC_WIDTH+1)'(partial);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fire) state_next = MUL;
      MUL:     if (mul_last) state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_shift   <= '0;
      b_reg     <= '0;
      partial   <= '0;
      count     <= '0;
      acc_out   <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            acc_out  <= '0;
            overflow <= 1'b0;
          end
          if (fire) begin
            a_shift <= PW'(a);
            b_reg   <= b;
            partial <= '0;
            count   <= '0;
          end
        end
        MUL: begin
          partial <= psum;
          a_shift <= a_shift << 1;
          b_reg   <= b_reg >> 1;
          count   <= count + 1'b1;
        end
        ACC: begin
          out_valid <= 1'b1;
          if (acc_sum[ACC_WIDTH]) overflow <= 1'b1;
`ifdef MAC_SATURATE_EN
          // A saturated accumulator carries again on any non-zero product,
          // so it stays pinned at all ones until clear.
          acc_out <= acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
          acc_out <= acc_sum[ACC_WIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_serial_accumulator.sv
module tb_mac_serial_accumulator;

  localparam int W  = 8;
  localparam int AW = 20;
  localparam longint LIMIT = 64'd1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          clear = 1'b0;
  logic [AW-1:0] acc_out;
  logic          out_valid;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  longint macc = 0;
  bit     movf = 1'b0;

  mac_serial_accumulator #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .clear(clear), .acc_out(acc_out),
    .out_valid(out_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  va;
    logic [W-1:0]  vb;
    logic          vclr;
    bit            vhold;
    logic [AW-1:0] eacc;
    logic          eovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Specification-level model: clear, then add a*b with overflow handling.
  function automatic void model_step(input int ma, input int mb, input bit mclr);
    longint s;
    if (mclr) begin
      macc = 0;
      movf = 1'b0;
    end
    s = macc + longint'(ma) * longint'(mb);
    if (s >= LIMIT) begin
      movf = 1'b1;
`ifdef MAC_SATURATE_EN
      macc = LIMIT - 1;
`else
      macc = s - LIMIT;
`endif
    end else begin
      macc = s;
    end
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tclr, input bit hold,
                        input longint eacc, input logic eovf, input string tag);
    int n = 0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready_before"}, in_ready, 1);
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    clear = tclr;
    @(posedge clk);
    #1;
    clear = 1'b0;
    if (hold) begin
      a = 8'd99;
      b = 8'd99;
    end else begin
      in_valid = 1'b0;
    end
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (in_ready || out_valid) busy_ok = 1'b0;
      if (hold) clear = k[0];
    end
    chk({tag, " busy_window"}, busy_ok, 1);
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b0;
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " ready_again"}, in_ready, 1);
    chk({tag, " acc"}, acc_out, eacc);
    chk({tag, " ovf"}, overflow, eovf);
    @(negedge clk);
    chk({tag, " pulse_end"}, out_valid, 0);
    chk({tag, " no_restart"}, in_ready, 1);
  endtask

  initial begin
    vecs[0] = '{8'd3,  8'd5,   1'b0, 1'b0, 20'd15,  1'b0};
    vecs[1] = '{8'd2,  8'd7,   1'b1, 1'b0, 20'd14,  1'b0};
    vecs[2] = '{8'd0,  8'd200, 1'b0, 1'b0, 20'd14,  1'b0};
    vecs[3] = '{8'd77, 8'd0,   1'b0, 1'b0, 20'd14,  1'b0};
    vecs[4] = '{8'd10, 8'd10,  1'b0, 1'b1, 20'd114, 1'b0};
    vecs[5] = '{8'd4,  8'd4,   1'b0, 1'b0, 20'd130, 1'b0};

    #12;
    chk("reset_acc", acc_out, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vclr, vecs[i].vhold,
             vecs[i].eacc, vecs[i].eovf, $sformatf("vec%0d", i));
      model_step(vecs[i].va, vecs[i].vb, vecs[i].vclr);
    end

    for (int i = 0; i < 16; i++) begin
      model_step(255, 255, i == 0);
      run_op(8'd255, 8'd255, i == 0, 1'b0, macc, movf, $sformatf("sq%0d", i));
    end
    chk("sq16_acc_const", acc_out, 1040400);
    chk("sq16_ovf_const", overflow, 0);
    model_step(255, 255, 1'b0);
    run_op(8'd255, 8'd255, 1'b0, 1'b0, macc, movf, "sq17");
`ifdef MAC_SATURATE_EN
    chk("sq17_acc_const", acc_out, 1048575);
`else
    chk("sq17_acc_const", acc_out, 56849);
`endif
    chk("sq17_ovf_const", overflow, 1);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) ra = 8'd255;
      rc = ($urandom_range(0, 7) == 0);
      model_step(ra, rb, rc);
      run_op(ra, rb, rc, 1'b0, macc, movf, $sformatf("rnd%0d", i));
    end

    // Make sure the accumulator is non-zero before the mid-operation reset.
    model_step(9, 9, 1'b1);
    run_op(8'd9, 8'd9, 1'b1, 1'b0, macc, movf, "pre_rst");
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'd50;
    b = 8'd50;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_acc", acc_out, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      bit seen = 1'b0;
      repeat (14) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_pulse", seen, 0);
    end
    macc = 0;
    movf = 1'b0;
    model_step(1, 1, 1'b0);
    run_op(8'd1, 8'd1, 1'b0, 1'b0, macc, movf, "post_rst");
    chk("post_rst_acc_const", acc_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
